// File: rtl/fa32bit.sv
// fa32bit: registered N-bit ripple-carry adder.
//   Computes {cout, s} = a + b + cin through a chain of 1-bit full-adder
//   cells, then captures the result in output flops on the rising clock edge.
// Ports:
//   clk   - clock; all state updates on the rising edge
//   rst_n - synchronous active-low reset; clears s and cout
//   a, b  - N-bit unsigned operands (not registered)
//   cin   - carry-in
//   s     - registered sum, bits [N-1:0] of a+b+cin
//   cout  - registered carry-out, bit N of a+b+cin

module fa32bit_cell (
   input  logic a,
   input  logic b,
   input  logic ci,
   output logic s,
   output logic co
);
   logic p;

   // The propagate term is shared by the sum and the carry.
   assign p  = a ^ b;
   assign s  = p ^ ci;
   assign co = (a & b) | (ci & p);
endmodule

module fa32bit #(
   parameter int N = 32
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   input  logic         cin,
   output logic [N-1:0] s,
   output logic         cout
);
   logic [N:0]   c;
   logic [N-1:0] sum_c;
   logic [N-1:0] s_d, s_q;
   logic         cout_d, cout_q;

   assign c[0] = cin;

   for (genvar i = 0; i < N; i++) begin : g_cell
      fa32bit_cell u_cell (
         .a  (a[i]),
         .b  (b[i]),
         .ci (c[i]),
         .s  (sum_c[i]),
         .co (c[i+1])
      );
   end

   // No enable: the register reloads every non-reset cycle.
   always_comb begin
      s_d    = sum_c;
      cout_d = c[N];
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s_q    <= '0;
         cout_q <= 1'b0;
      end else begin
         s_q    <= s_d;
         cout_q <= cout_d;
      end
   end

   // Outputs come straight from flops.
   assign s    = s_q;
   assign cout = cout_q;
endmodule

// File: tb/tb_fa32bit.sv
module tb_fa32bit;
   localparam int N = 32;

   logic         clk;
   logic         rst_n;
   logic [N-1:0] a, b;
   logic         cin;
   logic [N-1:0] s;
   logic         cout;

   int n_cmp = 0;
   int n_err = 0;

   // Reference model: the value {cout,s} must hold after each edge.
   logic [N:0] exp_val;
   logic       exp_vld = 1'b0;

   fa32bit #(.N(N)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .a     (a),
      .b     (b),
      .cin   (cin),
      .s     (s),
      .cout  (cout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (!rst_n) exp_val <= '0;
      else        exp_val <= {1'b0, a} + {1'b0, b} + (N+1)'(cin);
      exp_vld <= 1'b1;
   end

   // Every-cycle compare against the model, away from the active edge.
   always @(negedge clk) begin
      if (exp_vld) begin
         n_cmp++;
         if ({cout, s} !== exp_val) begin
            n_err++;
            $display("FAIL model t=%0t got cout=%0b s=%h want cout=%0b s=%h",
                     $time, cout, s, exp_val[N], exp_val[N-1:0]);
         end
      end
   end

   task automatic drive(input logic [N-1:0] ia, input logic [N-1:0] ib,
                        input logic ic, input logic ir);
      @(negedge clk);
      a = ia; b = ib; cin = ic; rst_n = ir;
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [N-1:0] es, input logic ec);
      n_cmp++;
      if (s !== es || cout !== ec) begin
         n_err++;
         $display("FAIL %s got cout=%0b s=%h want cout=%0b s=%h", name, cout, s, ec, es);
      end
   endtask

   initial begin
      a = '0; b = '0; cin = 1'b0; rst_n = 1'b0;

      // Reset held two edges with nonzero operands.
      drive(32'h12345678, 32'h12345678, 1'b1, 1'b0);
      check("reset1", 32'h0, 1'b0);
      drive(32'h12345678, 32'h12345678, 1'b1, 1'b0);
      check("reset2", 32'h0, 1'b0);
      drive(32'h12345678, 32'h12345678, 1'b1, 1'b1);
      check("release", 32'h2468ACF1, 1'b0);

      // Zero / ramp.
      drive(32'd0, 32'd0, 1'b0, 1'b1);          check("zero",   32'd0,     1'b0);
      drive(32'd10000, 32'd10000, 1'b0, 1'b1);  check("ramp1",  32'd20000, 1'b0);
      drive(32'd20000, 32'd20000, 1'b0, 1'b1);  check("ramp2",  32'd40000, 1'b0);
      // Unchanged inputs hold the output.
      drive(32'd20000, 32'd20000, 1'b0, 1'b1);  check("hold",   32'd40000, 1'b0);

      // Carry-out wrap.
      drive(32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b1); check("wrap1", 32'h0, 1'b1);
      drive(32'h80000000, 32'h80000000, 1'b0, 1'b1); check("wrap2", 32'h0, 1'b1);

      // Full carry ripple.
      drive(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b1); check("ripple1", 32'hFFFFFFFF, 1'b1);
      drive(32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b1); check("ripple2", 32'h0, 1'b1);

      // Carry-in only, alternating pattern.
      drive(32'h0, 32'h0, 1'b1, 1'b1);               check("cin_only", 32'h1, 1'b0);
      drive(32'h55555555, 32'hAAAAAAAA, 1'b0, 1'b1); check("alt",      32'hFFFFFFFF, 1'b0);

      // Ramp by 10000 every 10 cycles with a one-edge reset in the middle.
      for (int k = 0; k < 60; k++) begin
         logic [N-1:0] v;
         v = N'((k / 10) * 10000);
         drive(v, v, 1'b0, (k == 35) ? 1'b0 : 1'b1);
         if (k == 35) check("mid_reset", 32'h0, 1'b0);
         if (k == 36) check("after_reset", 32'd60000, 1'b0);
      end

      // Random stimulus, checked every cycle by the model compare.
      for (int k = 0; k < 10000; k++) begin
         logic [N-1:0] ra, rb;
         int sel;
         sel = $urandom_range(0, 7);
         ra  = $urandom;
         rb  = $urandom;
         if (sel == 0) ra = '1;
         if (sel == 1) rb = ~ra;
         drive(ra, rb, 1'($urandom_range(0, 1)), ($urandom_range(0, 99) != 0));
      end

      @(negedge clk);
      #1;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
